// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: turns completed SPI transactions into frame-memory writes,
// score updates and game-state updates for vga_top.
// Optional full-memory clear sweep is built when SNAKE_CMD_CLEAR_EN is defined.
module spi_cmd_ctrl #(
    parameter int unsigned MAX_SCORE = 999,
    parameter int unsigned DROP_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic [7:0]        command,
    input  logic [7:0]        databyte1,
    input  logic [7:0]        databyte2,
    output logic              we,
    output logic [9:0]        waddr,
    output logic [2:0]        wdata,
    output logic [9:0]        score,
    output logic [15:0]       state,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    localparam logic [9:0]        ScoreMax = 10'(MAX_SCORE);
    localparam logic [9:0]        LastAddr = 10'd1023;
    localparam logic [DROP_W-1:0] DropOne  = {{(DROP_W-1){1'b0}}, 1'b1};

    localparam logic [7:0] CmdWriteCell = 8'h01;
    localparam logic [7:0] CmdSetScore  = 8'h02;
    localparam logic [7:0] CmdAddScore  = 8'h03;
    localparam logic [7:0] CmdSetState  = 8'h04;
    localparam logic [7:0] CmdClear     = 8'h05;

    logic s1_q, s2_q, s3_q;
    logic str;

    logic [0:0]        fsm_q, fsm_d;
    logic [9:0]        clr_addr_q, clr_addr_d;
    logic              we_q, we_d;
    logic [9:0]        waddr_q, waddr_d;
    logic [2:0]        wdata_q, wdata_d;
    logic [9:0]        score_q, score_d;
    logic [15:0]       state_q, state_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic              slot_valid_q, slot_valid_d;
    logic [7:0]        slot_cmd_q, slot_cmd_d;
    logic [7:0]        slot_d1_q, slot_d1_d;
    logic [7:0]        slot_d2_q, slot_d2_d;

    logic              exec_valid;
    logic [7:0]        exec_cmd, exec_d1, exec_d2;
    logic [10:0]       add_sum;
    logic [9:0]        set_val;
    logic              new_cmd;

    // Unknown opcodes are never executed, queued or counted as drops.
    function automatic logic cmd_known(input logic [7:0] c);
        case (c)
            CmdWriteCell, CmdSetScore, CmdAddScore, CmdSetState: return 1'b1;
`ifdef SNAKE_CMD_CLEAR_EN
            CmdClear: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Synchronise cs; idle-high reset value means a cs held low through reset gives no strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= cs;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign str     = s2_q & ~s3_q;
    assign new_cmd = str & cmd_known(command);

    assign add_sum = {1'b0, score_q} + {3'b000, exec_d1};
    assign set_val = {exec_d2[1:0], exec_d1};

    // Pick what executes this cycle, manage the pending slot, run the sweep.
    always_comb begin
        fsm_d        = fsm_q;
        clr_addr_d   = clr_addr_q;
        we_d         = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        score_d      = score_q;
        state_d      = state_q;
        drop_d       = drop_q;
        slot_valid_d = slot_valid_q;
        slot_cmd_d   = slot_cmd_q;
        slot_d1_d    = slot_d1_q;
        slot_d2_d    = slot_d2_q;
        exec_valid   = 1'b0;
        exec_cmd     = slot_cmd_q;
        exec_d1      = slot_d1_q;
        exec_d2      = slot_d2_q;

        if (fsm_q == StIdle) begin
            if (slot_valid_q) begin
                // Slot drains first; a simultaneous strobe refills it.
                exec_valid   = 1'b1;
                slot_valid_d = 1'b0;
                if (new_cmd) begin
                    slot_valid_d = 1'b1;
                    slot_cmd_d   = command;
                    slot_d1_d    = databyte1;
                    slot_d2_d    = databyte2;
                end
            end else if (new_cmd) begin
                exec_valid = 1'b1;
                exec_cmd   = command;
                exec_d1    = databyte1;
                exec_d2    = databyte2;
            end
        end else begin
            if (new_cmd) begin
                if (!slot_valid_q) begin
                    slot_valid_d = 1'b1;
                    slot_cmd_d   = command;
                    slot_d1_d    = databyte1;
                    slot_d2_d    = databyte2;
                end else if (drop_q != {DROP_W{1'b1}}) begin
                    drop_d = drop_q + DropOne;
                end
            end
            // clr_addr_q is the address currently on waddr.
            if (clr_addr_q == LastAddr) begin
                fsm_d = StIdle;
            end else begin
                clr_addr_d = clr_addr_q + 10'd1;
                we_d       = 1'b1;
                waddr_d    = clr_addr_q + 10'd1;
                wdata_d    = 3'b000;
            end
        end

        if (exec_valid) begin
            case (exec_cmd)
                CmdWriteCell: begin
                    we_d    = 1'b1;
                    waddr_d = {exec_d2[1:0], exec_d1};
                    wdata_d = exec_d2[4:2];
                end
                CmdSetScore: begin
                    score_d = (set_val > ScoreMax) ? ScoreMax : set_val;
                end
                CmdAddScore: begin
                    score_d = (add_sum > {1'b0, ScoreMax}) ? ScoreMax : add_sum[9:0];
                end
                CmdSetState: begin
                    state_d = {exec_d2, exec_d1};
                end
`ifdef SNAKE_CMD_CLEAR_EN
                CmdClear: begin
                    fsm_d      = StClear;
                    clr_addr_d = 10'd0;
                    we_d       = 1'b1;
                    waddr_d    = 10'd0;
                    wdata_d    = 3'b000;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    // State, slot and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= StIdle;
            clr_addr_q   <= 10'd0;
            we_q         <= 1'b0;
            waddr_q      <= 10'd0;
            wdata_q      <= 3'b000;
            score_q      <= 10'd0;
            state_q      <= 16'd0;
            drop_q       <= '0;
            slot_valid_q <= 1'b0;
            slot_cmd_q   <= 8'd0;
            slot_d1_q    <= 8'd0;
            slot_d2_q    <= 8'd0;
        end else begin
            fsm_q        <= fsm_d;
            clr_addr_q   <= clr_addr_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            score_q      <= score_d;
            state_q      <= state_d;
            drop_q       <= drop_d;
            slot_valid_q <= slot_valid_d;
            slot_cmd_q   <= slot_cmd_d;
            slot_d1_q    <= slot_d1_d;
            slot_d2_q    <= slot_d2_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign score    = score_q;
    assign state    = state_q;
    assign drop_cnt = drop_q;

`ifdef SNAKE_CMD_CLEAR_EN
    assign busy = (fsm_q == StClear);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl.
// Sweep tests are compiled in when SNAKE_CMD_CLEAR_EN is defined.
module tb_spi_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic [7:0] command, databyte1, databyte2;
    logic       we;
    logic [9:0] waddr;
    logic [2:0] wdata;
    logic [9:0] score;
    logic [15:0] state;
    logic       busy;
    logic [7:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    spi_cmd_ctrl #(
        .MAX_SCORE(999),
        .DROP_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .command  (command),
        .databyte1(databyte1),
        .databyte2(databyte2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .score    (score),
        .state    (state),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Low pulse on cs with the bytes set up; returns on the negedge cs rises.
    task automatic send(input logic [7:0] c, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge clk);
        command   = c;
        databyte1 = d1;
        databyte2 = d2;
        cs        = 1'b0;
        cycles(3);
        cs = 1'b1;
    endtask

    task automatic wait_we(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (we === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int we_seen;
        int busy_seen;
        int bad;
        bit hit;

        reset     = 1'b1;
        cs        = 1'b1;
        command   = 8'h00;
        databyte1 = 8'h00;
        databyte2 = 8'h00;
        cycles(3);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_score", 32'(score), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        cycles(2);

        // WRITE_CELL: {2'b10, 0x2A} = 0x22A, 0x1E[4:2] = 3'b111
        send(8'h01, 8'h2A, 8'h1E);
        wait_we("wc_we");
        check("wc_waddr", 32'(waddr), 32'h22A);
        check("wc_wdata", 32'(wdata), 32'h7);
        @(negedge clk);
        check("wc_we_off", 32'(we), 32'd0);

        // SET_SCORE {2'b11, 0xE0} = 992
        send(8'h02, 8'hE0, 8'h03);
        cycles(5);
        check("set_score_992", 32'(score), 32'd992);
        // SET_SCORE 1023 saturates to 999
        send(8'h02, 8'hFF, 8'h03);
        cycles(5);
        check("set_score_sat", 32'(score), 32'd999);
        send(8'h03, 8'h05, 8'h00);
        cycles(5);
        check("add_score_sat", 32'(score), 32'd999);
        send(8'h02, 8'h0A, 8'h00);
        cycles(5);
        check("set_score_10", 32'(score), 32'd10);
        send(8'h03, 8'hFF, 8'h00);
        cycles(5);
        check("add_score_265", 32'(score), 32'd265);

        send(8'h04, 8'h34, 8'h12);
        cycles(5);
        check("set_state", 32'(state), 32'h1234);

        // Unknown opcode: nothing moves
        send(8'h7F, 8'h11, 8'h1F);
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (we === 1'b1) we_seen++;
        end
        check("unk_we", 32'(we_seen), 32'd0);
        check("unk_score", 32'(score), 32'd265);
        check("unk_state", 32'(state), 32'h1234);
        check("unk_waddr", 32'(waddr), 32'h22A);
        check("unk_drop", 32'(drop_cnt), 32'd0);

`ifdef SNAKE_CMD_CLEAR_EN
        // Full sweep with a WRITE_CELL queued and a SET_STATE dropped mid-sweep
        send(8'h05, 8'h00, 8'h00);
        wait_busy("clr_start");
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i > 0) @(negedge clk);
            if (!(we === 1'b1 && waddr === 10'(i) && wdata === 3'b000 && busy === 1'b1)) bad++;
            if (i == 100) begin
                command   = 8'h01;
                databyte1 = 8'h55;
                databyte2 = 8'h09;
                cs        = 1'b0;
            end
            if (i == 104) cs = 1'b1;
            if (i == 200) begin
                command   = 8'h04;
                databyte1 = 8'hAA;
                databyte2 = 8'hBB;
                cs        = 1'b0;
            end
            if (i == 204) cs = 1'b1;
        end
        check("clr_sweep_bad", 32'(bad), 32'd0);
        @(negedge clk);
        check("clr_end_busy", 32'(busy), 32'd0);
        check("clr_end_we", 32'(we), 32'd0);
        @(negedge clk);
        // Pending WRITE_CELL: {2'b01, 0x55} = 0x155, 0x09[4:2] = 3'b010
        check("pend_we", 32'(we), 32'd1);
        check("pend_waddr", 32'(waddr), 32'h155);
        check("pend_wdata", 32'(wdata), 32'h2);
        @(negedge clk);
        check("pend_we_off", 32'(we), 32'd0);
        check("drop_cnt_1", 32'(drop_cnt), 32'd1);
        check("drop_state", 32'(state), 32'h1234);

        // Reset in the middle of a sweep
        send(8'h05, 8'h00, 8'h00);
        wait_busy("clr2_start");
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (waddr === 10'd500) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("clr2_reach500", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_drop", 32'(drop_cnt), 32'd0);
        reset = 1'b0;
        cycles(2);
`else
        // Without the sweep, 0x05 is just an unknown opcode
        send(8'h05, 8'h00, 8'h00);
        we_seen   = 0;
        busy_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (we === 1'b1) we_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        check("noclr_we", 32'(we_seen), 32'd0);
        check("noclr_busy", 32'(busy_seen), 32'd0);
        check("noclr_score", 32'(score), 32'd265);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_score", 32'(score), 32'd0);
        check("rst2_state", 32'(state), 32'd0);
        reset = 1'b0;
        cycles(2);
`endif

        // cs held low through reset: no strobe on release, real strobe later
        command   = 8'h01;
        databyte1 = 8'h0F;
        databyte2 = 8'h12;
        cs        = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        we_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (we === 1'b1) we_seen++;
        end
        check("cs_low_rst_we", 32'(we_seen), 32'd0);
        cs = 1'b1;
        // {2'b10, 0x0F} = 0x20F, 0x12[4:2] = 3'b100
        wait_we("post_rst_we");
        check("post_rst_waddr", 32'(waddr), 32'h20F);
        check("post_rst_wdata", 32'(wdata), 32'h4);
        @(negedge clk);
        check("post_rst_we_off", 32'(we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
